// File: rtl/dec_key_pkg.sv
// Shared types and helpers for the debounced key encoder.
package dec_key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEB  = 2'd1,
    HOLD = 2'd2,
    REL  = 2'd3
  } state_t;

  localparam int CODE_W = 4;

  function automatic int unsigned popcount(input logic [15:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 16; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

  // Smallest width that can hold maxval.
  function automatic int unsigned bits_for(input int unsigned maxval);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) <= maxval) w++;
    return w;
  endfunction

endpackage

// File: rtl/dec_key_encoder_onehot_to_bin.sv
// Combinational key-line to binary index encoder with a multi-key flag.
module onehot_to_bin
  import dec_key_pkg::*;
#(
  parameter int KEYS = 10
) (
  input  logic [KEYS-1:0]   onehot_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              multi_o
);

  // OR of the indices of all set lines; exact when a single line is set.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (onehot_i[i]) idx_o = idx_o | CODE_W'(i);
    end
    multi_o = (popcount(16'(onehot_i)) > 1);
  end

endmodule

// File: rtl/dec_key_encoder.sv
// Debounced key encoder: synchroniser, press/release FSM, valid/ready code
// output and a BCD digit shift register fed by accepted codes.
module dec_key_encoder
  import dec_key_pkg::*;
#(
  parameter int KEYS     = 10,
  parameter int DEBOUNCE = 4,
  parameter int DIGITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEYS-1:0]      keys,
  input  logic                 clr,
  output logic [CODE_W-1:0]    code,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic                 multi_err,
  output logic [4*DIGITS-1:0]  digits,
  output logic [3:0]           ndigits
);

  localparam int unsigned CNT_W = bits_for(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [KEYS-1:0]     sync_q, samp_q, pat_q;
  logic [CNT_W-1:0]    cnt_q;
  state_t              state_q;
  logic [CODE_W-1:0]   code_q;
  logic                code_valid_q, multi_err_q;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [3:0]          ndigits_q, ndigits_d;
  logic [CODE_W-1:0]   pat_idx;
  logic                pat_multi;
  logic                hs;

  // Stage: two-flop synchroniser for the asynchronous key lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      samp_q <= '0;
    end else begin
      sync_q <= keys;
      samp_q <= sync_q;
    end
  end

  onehot_to_bin #(.KEYS(KEYS)) u_enc (
    .onehot_i (pat_q),
    .idx_o    (pat_idx),
    .multi_o  (pat_multi)
  );

  // Stage: debounce FSM with registered code/valid/error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pat_q        <= '0;
      cnt_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      multi_err_q  <= 1'b0;
    end else begin
      multi_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (samp_q != '0) begin
            pat_q   <= samp_q;
            cnt_q   <= CNT_ONE;
            state_q <= DEB;
          end
        end
        DEB: begin
          if (samp_q == '0) begin
            state_q <= IDLE;
          end else if (samp_q != pat_q) begin
            pat_q <= samp_q;
            cnt_q <= CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            if (pat_multi) begin
              multi_err_q <= 1'b1;
              state_q     <= REL;
            end else begin
              code_q       <= pat_idx;
              code_valid_q <= 1'b1;
              state_q      <= HOLD;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HOLD: begin
          if (code_ready) begin
            code_valid_q <= 1'b0;
            state_q      <= REL;
          end
        end
        REL: begin
          // Any key activity restarts the release count.
          if (cnt_q == CNT_MAX) state_q <= IDLE;
          else if (samp_q == '0) cnt_q <= cnt_q + CNT_ONE;
          else cnt_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hs = code_valid_q & code_ready;

  always_comb begin
    digits_d  = digits_q;
    ndigits_d = ndigits_q;
    if (clr) begin
      digits_d  = '0;
      ndigits_d = '0;
      if (hs) begin
        digits_d[CODE_W-1:0] = code_q;
        ndigits_d            = 4'd1;
      end
    end else if (hs) begin
      digits_d             = digits_q << CODE_W;
      digits_d[CODE_W-1:0] = code_q;
      if (ndigits_q != 4'(DIGITS)) ndigits_d = ndigits_q + 4'd1;
    end
  end

  // Stage: digit shift register, updated on the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q  <= '0;
      ndigits_q <= '0;
    end else begin
      digits_q  <= digits_d;
      ndigits_q <= ndigits_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign multi_err  = multi_err_q;
  assign digits     = digits_q;
  assign ndigits    = ndigits_q;

endmodule

// File: tb/tb_dec_key_encoder.sv
// Scoreboard bench for dec_key_encoder with default parameters.
module tb_dec_key_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  keys;
  logic        clr;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready;
  logic        multi_err;
  logic [15:0] digits;
  logic [3:0]  ndigits;

  int n_cmp = 0;
  int n_err = 0;
  int merr_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  logic [15:0] dig_m = '0;
  logic [3:0]  nd_m = '0;

  always #5 clk = ~clk;

  dec_key_encoder #(.KEYS(10), .DEBOUNCE(4), .DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .keys       (keys),
    .clr        (clr),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .multi_err  (multi_err),
    .digits     (digits),
    .ndigits    (ndigits)
  );

  // Monitor: handshakes and error pulses as seen by the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (code_valid === 1'b1 && code_ready === 1'b1) obs_q.push_back(code);
      if (multi_err === 1'b1) merr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_code(input logic [3:0] k);
    exp_q.push_back(k);
    dig_m = {dig_m[11:0], k};
    if (nd_m != 4'd4) nd_m = nd_m + 4'd1;
  endtask

  task automatic press(input int k, input int hold);
    keys = '0;
    keys[k] = 1'b1;
    tick(hold);
    keys = '0;
    tick(12);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (code_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; keys = '0; clr = 1'b0; code_ready = 1'b1;
    tick(2);
    n_cmp++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", code_valid); end
    n_cmp++; if (code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", code); end
    n_cmp++; if (multi_err !== 1'b0) begin n_err++; $display("FAIL reset_merr: got %b want 0", multi_err); end
    n_cmp++; if (digits !== 16'h0) begin n_err++; $display("FAIL reset_digits: got %h want 0", digits); end
    n_cmp++; if (ndigits !== 4'd0) begin n_err++; $display("FAIL reset_ndigits: got %0d want 0", ndigits); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_press_timing();
    logic [3:0] e, o;
    code_ready = 1'b1;
    keys = '0; keys[7] = 1'b1;
    expect_code(4'd7);
    tick(6);
    n_cmp++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL k7_early: valid %b want 0", code_valid); end
    tick(1);
    n_cmp++; if (code_valid !== 1'b1 || code !== 4'd7) begin n_err++; $display("FAIL k7_rise: valid %b code %0d want 1/7", code_valid, code); end
    tick(1);
    n_cmp++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL k7_onecycle: valid %b want 0", code_valid); end
    tick(2);
    keys = '0;
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL k7_code: none, want %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL k7_code: got %0d want %0d", o, e); end end
    end
    n_cmp++; if (digits !== dig_m || ndigits !== nd_m) begin n_err++; $display("FAIL k7_digits: got %h/%0d want %h/%0d", digits, ndigits, dig_m, nd_m); end
  endtask

  task automatic test_glitch();
    int m0;
    m0 = merr_cnt;
    for (int i = 0; i < 10; i++) begin
      keys = '0;
      if (i % 2 == 0) keys[3] = 1'b1;
      tick(2);
    end
    keys = '0;
    tick(12);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL glitch_code: got %0d outputs want 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (merr_cnt != m0) begin n_err++; $display("FAIL glitch_merr: got %0d pulses want 0", merr_cnt - m0); end
    n_cmp++; if (digits !== dig_m || ndigits !== nd_m) begin n_err++; $display("FAIL glitch_digits: got %h/%0d want %h/%0d", digits, ndigits, dig_m, nd_m); end
  endtask

  task automatic test_multi();
    int m0;
    logic [3:0] e, o;
    m0 = merr_cnt;
    keys = '0; keys[2] = 1'b1; keys[5] = 1'b1;
    tick(10);
    keys = '0;
    tick(12);
    n_cmp++; if (merr_cnt - m0 != 1) begin n_err++; $display("FAIL multi_pulse: got %0d pulses want 1", merr_cnt - m0); end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL multi_code: got %0d outputs want 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (digits !== dig_m || ndigits !== nd_m) begin n_err++; $display("FAIL multi_digits: got %h/%0d want %h/%0d", digits, ndigits, dig_m, nd_m); end
    expect_code(4'd1);
    press(1, 10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL after_multi_code: none, want %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL after_multi_code: got %0d want %0d", o, e); end end
    end
    n_cmp++; if (digits !== dig_m || ndigits !== nd_m) begin n_err++; $display("FAIL after_multi_digits: got %h/%0d want %h/%0d", digits, ndigits, dig_m, nd_m); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e, o;
    for (int k = 1; k <= 5; k++) begin
      expect_code(4'(k));
      press(k, 8);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL seq_code: none, want %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL seq_code: got %0d want %0d", o, e); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL seq_extra: %0d unexpected outputs", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (digits !== 16'h2345 || ndigits !== 4'd4) begin n_err++; $display("FAIL seq_digits: got %h/%0d want 2345/4", digits, ndigits); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3:0] e, o;
    code_ready = 1'b0;
    keys = '0; keys[9] = 1'b1;
    expect_code(4'd9);
    wait_valid(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: valid %b want 1", code_valid); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (code_valid !== 1'b1 || code !== 4'd9) begin n_err++; $display("FAIL bp_hold: cycle %0d valid %b code %0d want 1/9", i, code_valid, code); end
      if (i == 2) begin keys = '0; keys[4] = 1'b1; end
      tick(1);
    end
    code_ready = 1'b1;
    tick(1);
    n_cmp++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop: valid %b want 0", code_valid); end
    tick(4);
    keys = '0;
    tick(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL bp_code: none, want %0d", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin n_err++; $display("FAIL bp_code: got %0d want %0d", o, e); end end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL bp_extra: %0d unexpected outputs", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (digits !== dig_m || ndigits !== nd_m) begin n_err++; $display("FAIL bp_digits: got %h/%0d want %h/%0d", digits, ndigits, dig_m, nd_m); end
  endtask

  task automatic test_clear();
    bit ok;
    logic [3:0] o;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    dig_m = '0; nd_m = '0;
    n_cmp++; if (digits !== 16'h0 || ndigits !== 4'd0) begin n_err++; $display("FAIL clr_only: got %h/%0d want 0/0", digits, ndigits); end
    code_ready = 1'b0;
    keys = '0; keys[6] = 1'b1;
    wait_valid(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL clr_timeout: valid %b want 1", code_valid); end
    clr = 1'b1; code_ready = 1'b1;
    tick(1);
    clr = 1'b0;
    dig_m = 16'h0006; nd_m = 4'd1;
    n_cmp++; if (digits !== dig_m || ndigits !== nd_m) begin n_err++; $display("FAIL clr_hs: got %h/%0d want 0006/1", digits, ndigits); end
    n_cmp++;
    if (obs_q.size() == 0) begin n_err++; $display("FAIL clr_code: none, want 6"); end
    else begin o = obs_q.pop_front(); if (o !== 4'd6) begin n_err++; $display("FAIL clr_code: got %0d want 6", o); end end
    keys = '0;
    tick(12);
  endtask

  task automatic test_reset_hold();
    bit ok;
    code_ready = 1'b0;
    keys = '0; keys[2] = 1'b1;
    wait_valid(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rsth_timeout: valid %b want 1", code_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (code_valid !== 1'b0 || code !== 4'd0 || multi_err !== 1'b0) begin n_err++; $display("FAIL rsth_ctrl: valid %b code %0d merr %b want 0", code_valid, code, multi_err); end
    n_cmp++; if (digits !== 16'h0 || ndigits !== 4'd0) begin n_err++; $display("FAIL rsth_digits: got %h/%0d want 0/0", digits, ndigits); end
    keys = '0;
    tick(2);
    rst = 1'b0;
    code_ready = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_press_timing();
    test_glitch();
    test_multi();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
